// File: rtl/rf_stream_server_pkg.sv
// Shared types for the polynomial register file and its stream interface.
package rf_stream_server_pkg;

  localparam int unsigned NREG        = 8;
  localparam int unsigned N           = 16;
  localparam int unsigned COEFF_W     = 16;
  localparam int unsigned REG_IDX_W   = $clog2(NREG);
  localparam int unsigned COEFF_IDX_W = $clog2(N);

  typedef logic [COEFF_W-1:0]     coeff_t;
  typedef logic [REG_IDX_W-1:0]   reg_idx_t;
  typedef logic [COEFF_IDX_W-1:0] coeff_idx_t;

  localparam coeff_idx_t LAST_IDX = coeff_idx_t'(N - 1);

  // One beat of a coefficient stream.
  typedef struct packed {
    logic   valid;
    coeff_t coefficient;
    logic   last;
  } beat_t;

endpackage

// File: rtl/rf_stream_server_if.sv
// Command, stream and preload signals between controller/functional units and the register file.
interface rf_stream_server_if;
  import rf_stream_server_pkg::*;

  logic       register_file_ready;
  logic       start_operation;
  logic       use_source1;
  reg_idx_t   source0_register_index;
  reg_idx_t   source1_register_index;
  reg_idx_t   destination_register_index;

  logic       source0_valid;
  coeff_t     source0_coefficient;
  logic       source0_last;
  logic       source1_valid;
  coeff_t     source1_coefficient;
  logic       source1_last;

  logic       destination_valid;
  coeff_t     destination_coefficient;
  logic       destination_last;

  logic       load_valid;
  reg_idx_t   load_register_index;
  coeff_idx_t load_coefficient_index;
  coeff_t     load_coefficient;

  logic       protocol_error;

  // Register-file side.
  modport slave (
    output register_file_ready, source0_valid, source0_coefficient, source0_last,
           source1_valid, source1_coefficient, source1_last, protocol_error,
    input  start_operation, use_source1, source0_register_index, source1_register_index,
           destination_register_index, destination_valid, destination_coefficient,
           destination_last, load_valid, load_register_index, load_coefficient_index,
           load_coefficient
  );

  // Controller / functional-unit side.
  modport master (
    input  register_file_ready, source0_valid, source0_coefficient, source0_last,
           source1_valid, source1_coefficient, source1_last, protocol_error,
    output start_operation, use_source1, source0_register_index, source1_register_index,
           destination_register_index, destination_valid, destination_coefficient,
           destination_last, load_valid, load_register_index, load_coefficient_index,
           load_coefficient
  );

endinterface

// File: rtl/rf_storage.sv
// NREG x N coefficient array: two combinational read ports, one write port shared by preload and writeback.
module rf_storage
  import rf_stream_server_pkg::*;
(
  input  logic       clk,
  input  reg_idx_t   rd0_reg,
  input  coeff_idx_t rd0_idx,
  output coeff_t     rd0_data_c,
  input  reg_idx_t   rd1_reg,
  input  coeff_idx_t rd1_idx,
  output coeff_t     rd1_data_c,
  input  logic       load_en,
  input  reg_idx_t   load_reg,
  input  coeff_idx_t load_idx,
  input  coeff_t     load_data,
  input  logic       wb_en,
  input  reg_idx_t   wb_reg,
  input  coeff_idx_t wb_idx,
  input  coeff_t     wb_data
);

  coeff_t mem [NREG][N];

  // Single write port; load and writeback are never active together (idle vs busy).
  always_ff @(posedge clk) begin
    if (wb_en) begin
      mem[wb_reg][wb_idx] <= wb_data;
    end else if (load_en) begin
      mem[load_reg][load_idx] <= load_data;
    end
  end

  assign rd0_data_c = mem[rd0_reg][rd0_idx];
  assign rd1_data_c = mem[rd1_reg][rd1_idx];

endmodule

// File: rtl/rf_stream_server.sv
// Register-file end of the source/destination stream protocol: streams operands out, captures the result.
module rf_stream_server
  import rf_stream_server_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  rf_stream_server_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e     state;
  logic       ready;
  logic       error;
  beat_t      src0_beat;
  beat_t      src1_beat;
  reg_idx_t   src0_q;
  reg_idx_t   src1_q;
  reg_idx_t   dst_q;
  logic       use_src1_q;
  coeff_idx_t rd_idx;
  coeff_idx_t wr_idx;

  coeff_t     rd0_c;
  coeff_t     rd1_c;
  logic       load_en_c;
  logic       wb_en_c;
  logic       wb_done_c;
  logic       wb_err_c;
  logic       rd_last_c;

  // Write-port qualification, completion and protocol-violation detection.
  always_comb begin
    load_en_c = (state == ST_IDLE) && bus.load_valid;
    wb_en_c   = (state != ST_IDLE) && bus.destination_valid;
    wb_done_c = wb_en_c && (bus.destination_last || (wr_idx == LAST_IDX));
    wb_err_c  = (wb_en_c && (bus.destination_last != (wr_idx == LAST_IDX)))
             || ((state == ST_IDLE) && bus.destination_valid);
    rd_last_c = (rd_idx == LAST_IDX);
  end

  rf_storage u_storage (
    .clk        (clk),
    .rd0_reg    (src0_q),
    .rd0_idx    (rd_idx),
    .rd0_data_c (rd0_c),
    .rd1_reg    (src1_q),
    .rd1_idx    (rd_idx),
    .rd1_data_c (rd1_c),
    .load_en    (load_en_c),
    .load_reg   (bus.load_register_index),
    .load_idx   (bus.load_coefficient_index),
    .load_data  (bus.load_coefficient),
    .wb_en      (wb_en_c),
    .wb_reg     (dst_q),
    .wb_idx     (wr_idx),
    .wb_data    (bus.destination_coefficient)
  );

  // Operation FSM with registered source beats, ready and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ready      <= 1'b0;
      error      <= 1'b0;
      src0_beat  <= '0;
      src1_beat  <= '0;
      src0_q     <= '0;
      src1_q     <= '0;
      dst_q      <= '0;
      use_src1_q <= 1'b0;
      rd_idx     <= '0;
      wr_idx     <= '0;
    end else begin
      if (wb_err_c) begin
        error <= 1'b1;
      end
      if (wb_en_c) begin
        wr_idx <= wr_idx + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          src0_beat <= '0;
          src1_beat <= '0;
          if (bus.start_operation && ready) begin
            src0_q     <= bus.source0_register_index;
            src1_q     <= bus.source1_register_index;
            dst_q      <= bus.destination_register_index;
            use_src1_q <= bus.use_source1;
            rd_idx     <= '0;
            wr_idx     <= '0;
            ready      <= 1'b0;
            state      <= ST_STREAM;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (wb_done_c) begin
            // Early completion (destination_last before the end) aborts the stream.
            src0_beat <= '0;
            src1_beat <= '0;
            ready     <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            src0_beat <= '{valid: 1'b1, coefficient: rd0_c, last: rd_last_c};
            src1_beat <= '{valid: use_src1_q,
                           coefficient: use_src1_q ? rd1_c : '0,
                           last: use_src1_q && rd_last_c};
            rd_idx    <= rd_idx + 1'b1;
            if (rd_last_c) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          src0_beat <= '0;
          src1_beat <= '0;
          if (wb_done_c) begin
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          src0_beat <= '0;
          src1_beat <= '0;
          ready     <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.register_file_ready = ready;
  assign bus.protocol_error      = error;
  assign bus.source0_valid       = src0_beat.valid;
  assign bus.source0_coefficient = src0_beat.coefficient;
  assign bus.source0_last        = src0_beat.last;
  assign bus.source1_valid       = src1_beat.valid;
  assign bus.source1_coefficient = src1_beat.coefficient;
  assign bus.source1_last        = src1_beat.last;

endmodule

// File: tb/tb_rf_stream_server.sv
// Self-checking bench for rf_stream_server against a whole-register reference model.
module tb_rf_stream_server;
  import rf_stream_server_pkg::*;

  localparam int OP_ADD  = 0;
  localparam int OP_DBL  = 1;
  localparam int OP_PASS = 2;
  localparam int OP_SUB  = 3;
  localparam int OUT_W   = 6 + 2 * COEFF_W;
  localparam int BEAT_W  = 3 + COEFF_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rf_stream_server_if bus ();

  rf_stream_server dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  coeff_t model_mem [NREG][N];
  int     n_checks = 0;
  int     n_fail = 0;
  logic   err_exp = 1'b0;

  // Functional-unit behaviour, applied to whole operands.
  function automatic coeff_t fu(input int op, input coeff_t a, input coeff_t b);
    case (op)
      OP_ADD:  return coeff_t'(a + b);
      OP_DBL:  return coeff_t'(a + a);
      OP_SUB:  return coeff_t'(a - b);
      default: return a;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] outs_now();
    return {bus.register_file_ready, bus.protocol_error,
            bus.source0_valid, bus.source0_coefficient, bus.source0_last,
            bus.source1_valid, bus.source1_coefficient, bus.source1_last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_operation            = 1'b0;
    bus.use_source1                = 1'b0;
    bus.source0_register_index     = '0;
    bus.source1_register_index     = '0;
    bus.destination_register_index = '0;
    bus.destination_valid          = 1'b0;
    bus.destination_coefficient    = '0;
    bus.destination_last           = 1'b0;
    bus.load_valid                 = 1'b0;
    bus.load_register_index        = '0;
    bus.load_coefficient_index     = '0;
    bus.load_coefficient           = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    err_exp = 1'b0;
  endtask

  task automatic load_word(input int r, input int i, input coeff_t v);
    bus.load_valid             = 1'b1;
    bus.load_register_index    = reg_idx_t'(r);
    bus.load_coefficient_index = coeff_idx_t'(i);
    bus.load_coefficient       = v;
    tick();
    bus.load_valid = 1'b0;
    model_mem[r][i] = v;
  endtask

  // Full operation: checks every source beat, ready timing and final error state.
  task automatic test_stream(input int s0, input int s1, input int d, input logic use1,
                             input int op, input int gap);
    coeff_t a [N];
    coeff_t b [N];
    coeff_t r [N];
    coeff_t e1;
    logic [BEAT_W-1:0] got, exp;
    logic lst;
    for (int i = 0; i < N; i++) begin
      a[i] = model_mem[s0][i];
      b[i] = model_mem[s1][i];
      r[i] = fu(op, a[i], use1 ? b[i] : coeff_t'(0));
    end
    n_checks++;
    if (bus.register_file_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_start: got %b expected 1", bus.register_file_ready);
    end
    bus.start_operation            = 1'b1;
    bus.use_source1                = use1;
    bus.source0_register_index     = reg_idx_t'(s0);
    bus.source1_register_index     = reg_idx_t'(s1);
    bus.destination_register_index = reg_idx_t'(d);
    tick();
    bus.start_operation            = 1'b0;
    bus.use_source1                = logic'($urandom_range(1));
    bus.source0_register_index     = reg_idx_t'($urandom);
    bus.source1_register_index     = reg_idx_t'($urandom);
    bus.destination_register_index = reg_idx_t'($urandom);
    n_checks++;
    if ({bus.register_file_ready, bus.source0_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_edge: got ready/valid %b%b expected 00",
               bus.register_file_ready, bus.source0_valid);
    end
    for (int k = 0; k < N; k++) begin
      tick();
      lst = (k == N - 1);
      got = {bus.register_file_ready, bus.source0_valid, bus.source0_coefficient, bus.source0_last};
      exp = {1'b0, 1'b1, a[k], lst};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL src0_beat[%0d]: got %h expected %h", k, got, exp);
      end
      e1  = use1 ? b[k] : coeff_t'(0);
      got = {1'b0, bus.source1_valid, bus.source1_coefficient, bus.source1_last};
      exp = {1'b0, use1, e1, use1 & lst};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL src1_beat[%0d]: got %h expected %h", k, got, exp);
      end
      bus.destination_valid       = !(lst && gap > 0);
      bus.destination_coefficient = r[k];
      bus.destination_last        = lst;
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      n_checks++;
      if ({bus.register_file_ready, bus.source0_valid, bus.source1_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL drain_gap[%0d]: got ready/v0/v1 %b%b%b expected 000", g,
                 bus.register_file_ready, bus.source0_valid, bus.source1_valid);
      end
      bus.destination_valid = (g == gap - 1);
    end
    tick();
    bus.destination_valid = 1'b0;
    bus.destination_last  = 1'b0;
    n_checks++;
    if ({bus.register_file_ready, bus.source0_valid, bus.source1_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL ready_return: got ready/v0/v1 %b%b%b expected 100",
               bus.register_file_ready, bus.source0_valid, bus.source1_valid);
    end
    n_checks++;
    if (bus.protocol_error !== err_exp) begin
      n_fail++;
      $display("FAIL protocol_error: got %b expected %b", bus.protocol_error, err_exp);
    end
    for (int i = 0; i < N; i++) model_mem[d][i] = r[i];
  endtask

  // Reads a register back by streaming it through an in-place pass operation.
  task automatic verify_reg(input int r);
    test_stream(r, r, r, 1'b0, OP_PASS, 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (outs_now() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs_now());
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.register_file_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b expected 0", bus.register_file_ready);
    end
    tick();
    n_checks++;
    if ({bus.register_file_ready, bus.protocol_error} !== 2'b10) begin
      n_fail++;
      $display("FAIL ready_after_release: got ready/err %b%b expected 10",
               bus.register_file_ready, bus.protocol_error);
    end
    for (int r = 0; r < NREG; r++)
      for (int i = 0; i < N; i++) load_word(r, i, coeff_t'($urandom));
  endtask

  task automatic test_binary();
    for (int i = 0; i < N; i++) load_word(0, i, coeff_t'(i));
    for (int i = 0; i < N; i++) load_word(1, i, coeff_t'(100 + i));
    test_stream(0, 1, 2, 1'b1, OP_ADD, 0);
    verify_reg(2);
  endtask

  task automatic test_unary_inplace();
    for (int i = 0; i < N; i++) load_word(3, i, coeff_t'(7));
    test_stream(3, 6, 3, 1'b0, OP_DBL, 0);
    verify_reg(3);
  endtask

  task automatic test_dest_last_error();
    coeff_t a [N];
    logic [BEAT_W-1:0] got, exp;
    for (int i = 0; i < N; i++) a[i] = model_mem[4][i];
    bus.start_operation            = 1'b1;
    bus.use_source1                = 1'b0;
    bus.source0_register_index     = reg_idx_t'(4);
    bus.destination_register_index = reg_idx_t'(5);
    tick();
    bus.start_operation = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      got = {bus.register_file_ready, bus.source0_valid, bus.source0_coefficient, bus.source0_last};
      exp = {1'b0, 1'b1, a[k], 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL err_run_beat[%0d]: got %h expected %h", k, got, exp);
      end
      bus.destination_valid       = 1'b1;
      bus.destination_coefficient = fu(OP_DBL, a[k], coeff_t'(0));
      bus.destination_last        = (k == 5);
    end
    tick();
    bus.destination_valid = 1'b0;
    bus.destination_last  = 1'b0;
    n_checks++;
    if ({bus.register_file_ready, bus.protocol_error, bus.source0_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL early_last: got ready/err/v0 %b%b%b expected 110",
               bus.register_file_ready, bus.protocol_error, bus.source0_valid);
    end
    err_exp = 1'b1;
    for (int i = 0; i <= 5; i++) model_mem[5][i] = fu(OP_DBL, a[i], coeff_t'(0));
    verify_reg(5);
    do_reset();
    n_checks++;
    if (bus.protocol_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_cleared_by_reset: got %b expected 0", bus.protocol_error);
    end
  endtask

  task automatic test_idle_dest_error();
    for (int c = 0; c < 3; c++) begin
      bus.destination_valid       = 1'b1;
      bus.destination_coefficient = coeff_t'($urandom);
      bus.destination_last        = logic'($urandom_range(1));
      tick();
    end
    bus.destination_valid = 1'b0;
    bus.destination_last  = 1'b0;
    n_checks++;
    if ({bus.register_file_ready, bus.protocol_error} !== 2'b11) begin
      n_fail++;
      $display("FAIL idle_dest: got ready/err %b%b expected 11",
               bus.register_file_ready, bus.protocol_error);
    end
    err_exp = 1'b1;
    verify_reg(0);
    do_reset();
  endtask

  task automatic test_ignored_start_and_reset();
    coeff_t a [N];
    coeff_t b [N];
    logic [BEAT_W-1:0] got, exp;
    for (int i = 0; i < N; i++) begin
      a[i] = model_mem[0][i];
      b[i] = model_mem[1][i];
    end
    bus.start_operation            = 1'b1;
    bus.use_source1                = 1'b1;
    bus.source0_register_index     = reg_idx_t'(0);
    bus.source1_register_index     = reg_idx_t'(1);
    bus.destination_register_index = reg_idx_t'(2);
    tick();
    bus.start_operation = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      got = {bus.source0_valid, bus.source0_coefficient, bus.source1_valid, bus.source1_coefficient};
      exp = {1'b1, a[k], 1'b1, b[k]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ignored_start_beat[%0d]: got %h expected %h", k, got, exp);
      end
      if (k == 8) break;
      bus.start_operation            = (k == 3);
      bus.source0_register_index     = reg_idx_t'(6);
      bus.source1_register_index     = reg_idx_t'(7);
      bus.destination_register_index = reg_idx_t'(4);
      bus.load_valid                 = (k == 5);
      bus.load_register_index        = reg_idx_t'(2);
      bus.load_coefficient_index     = coeff_idx_t'(12);
      bus.load_coefficient           = coeff_t'(16'hdead);
      bus.destination_valid          = 1'b1;
      bus.destination_coefficient    = fu(OP_ADD, a[k], b[k]);
      bus.destination_last           = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (outs_now() !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: got %h expected 0", outs_now());
    end
    idle_inputs();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (bus.register_file_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_midop_reset: got %b expected 1", bus.register_file_ready);
    end
    err_exp = 1'b0;
    for (int i = 0; i < 8; i++) model_mem[2][i] = fu(OP_ADD, a[i], b[i]);
    verify_reg(2);
  endtask

  task automatic test_back_to_back();
    test_stream(4, 5, 6, 1'b1, OP_SUB, 0);
    test_stream(6, 4, 7, 1'b1, OP_ADD, 0);
    test_stream(7, 0, 7, 1'b0, OP_DBL, 0);
    verify_reg(6);
    verify_reg(7);
  endtask

  task automatic test_random();
    int s0, s1, d, op, gap;
    logic use1;
    for (int it = 0; it < 8; it++) begin
      s0   = int'($urandom_range(NREG - 1));
      s1   = int'($urandom_range(NREG - 1));
      d    = int'($urandom_range(NREG - 1));
      op   = int'($urandom_range(3));
      gap  = int'($urandom_range(2));
      use1 = logic'($urandom_range(1));
      test_stream(s0, s1, d, use1, op, gap);
      verify_reg(d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_binary();
    test_unary_inplace();
    test_dest_last_error();
    test_idle_dest_error();
    test_ignored_start_and_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_stream_server.md
# rf_stream_server

Streaming responder for the polynomial register file protocol: it owns NREG polynomial registers of N coefficients each. On a one-cycle `start_operation` pulse it streams one or two source registers out one coefficient per cycle with valid/last, and it captures the returned destination stream into the destination register. It sits between the CPU's operation controller and the per-coefficient functional units (adder, multiplier, NTT), on the register-file end of the source/destination stream interface.

## Interface
- NREG, 8: number of polynomial registers
- N, 16: coefficients per register; power of two, at least 2
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- register_file_ready  out  1  idle and able to accept `start_operation`
- start_operation  in  1  one-cycle command pulse
- use_source1  in  1  1 = binary op (stream source1), 0 = unary op
- source0_register_index, source1_register_index, destination_register_index  in  $clog2(NREG) each  operand/result register selects
- source0_valid / source0_coefficient / source0_last  out  1 / coeff_t / 1  source0 stream
- source1_valid / source1_coefficient / source1_last  out  1 / coeff_t / 1  source1 stream
- destination_valid / destination_coefficient / destination_last  in  1 / coeff_t / 1  result stream
- load_valid  in  1  preload strobe (bench/boot)
- load_register_index  in  $clog2(NREG)  preload register
- load_coefficient_index  in  $clog2(N)  preload slot
- load_coefficient  in  coeff_t  preload data
- protocol_error  out  1  sticky protocol-violation flag

## Operation
- Storage: NREG×N array of coeff_t. Not reset; contents are undefined until loaded.
- FSM states: ST_IDLE, ST_STREAM, ST_DRAIN.
- ST_IDLE: `register_file_ready`=1. On `start_operation`, latch all three indices and `use_source1`, clear rd_idx and wr_idx, go to ST_STREAM. `load_valid` writes storage only in ST_IDLE; it is ignored in other states.
- ST_STREAM: each cycle drive source0 = mem[src0][rd_idx] with valid=1. If use_source1, also drive source1 = mem[src1][rd_idx] with valid=1; otherwise source1 valid=0 and coefficient=0. `*_last`=1 when rd_idx==N-1. rd_idx increments every cycle. After emitting N-1, go to ST_DRAIN.
- Writeback is active in ST_STREAM and ST_DRAIN. Each `destination_valid` writes mem[dst][wr_idx] and increments wr_idx.
- Completion: a write with `destination_last`=1 or wr_idx==N-1 returns to ST_IDLE.
- Error conditions set `protocol_error`:
  - `destination_last` with wr_idx≠N-1.
  - wr_idx==N-1 without `destination_last`.
  - `destination_valid` in ST_IDLE. The data is dropped.
- `protocol_error` clears only on reset.
- `start_operation` while not ready is ignored and is not an error.
- In-place operation (dst equals a source) is legal: slot i is written at the end of the cycle that read slot i, and later reads use slots above i.

## Timing
- Reset asserted: all outputs 0, state ST_IDLE. `register_file_ready` rises on the first clk edge after reset_n deasserts.
- All source outputs and `register_file_ready` are registered.
- Start pulse sampled at edge T:
  - `register_file_ready`=0 from T.
  - First source beat valid in cycle T+1.
  - Last beat in cycle T+N.
- With combinational functional units, destination beats coincide with source beats. The last write occurs at edge T+N+1, and `register_file_ready`=1 after that edge.
- A new start may be sampled on the first edge at which ready=1, with no dead cycle.
- Writeback latency from `destination_valid` to stored data: 1 edge. A load followed by a start on consecutive cycles sees the loaded value.
- Source valid is never deasserted mid-stream; there is no backpressure. Destination beats may be gapped in ST_DRAIN.
- Reset mid-operation returns to ST_IDLE immediately. Partially written destination slots keep their new values.

## Structure
- coeff_t and NREG come from the shared types package; N is added to that package.
- A state_e enum local to this module.
- One sub-module: rf_storage (NREG×N coeff_t array, two combinational read ports, one write port, write muxed between load and destination).

## Test plan
- Reset: reset_n=0 → all outputs 0. Release → `register_file_ready`=1 after one edge; `protocol_error`=0.
- Binary stream: load R0[i]=i, R1[i]=100+i; start src0=0, src1=1, dst=2; bench adds → source beats T+1..T+16 with last at i=15. R2[i]=100+2i. Ready returns at T+17.
- Unary in place: load R3[i]=7; start use_source1=0, src0=dst=3; bench returns coeff×2 → source1_valid stays 0 throughout. R3[i]=14 for all i. No error.
- Protocol errors:
  - `destination_last` at beat 5 → return to idle, `protocol_error`=1.
  - Separate run with `destination_valid` while idle → R unchanged, `protocol_error`=1.
- Ignored start and mid-op reset: `start_operation` pulsed at beat 3 → no restart. Reset asserted at beat 8 → outputs 0 immediately; R2 slots 0–7 hold new values, slots 8–15 hold old values.
- Back-to-back ops: second start on the first ready cycle → second stream begins exactly one cycle later with correct indices.
